// File: rtl/pattern_merge_if.sv
// Handshake, pattern and observability bundle for pattern_merge_pipe.
// The master side drives stimulus; the slave side is the pipeline.
interface pattern_merge_if #(
  parameter int CH    = 4,
  parameter int SIG_W = 16,
  parameter int CNT_W = 16
);
  logic              in_vld;
  logic              in_rdy;
  logic [3*CH-1:0]   in_p;
  logic              out_vld;
  logic              out_rdy;
  logic [3*CH-1:0]   out_p;
  logic              sig_clr;
  logic [SIG_W-1:0]  sig;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output in_vld, in_p, out_rdy, sig_clr,
    input  in_rdy, out_vld, out_p, sig, out_cnt
  );

  modport slave (
    input  in_vld, in_p, out_rdy, sig_clr,
    output in_rdy, out_vld, out_p, sig, out_cnt
  );
endinterface

// File: rtl/pattern_merge_pipe.sv
// CH-channel merged gate patterns, DEPTH-stage valid/ready pipeline,
// plus MISR signature and handshake counter over delivered words.
module pattern_merge_lane (
    input  logic [2:0] abc,
    input  logic [2:0] abc_nb,
    output logic [2:0] o
);
    logic l1372, l1508, l6147;
    logic n1372, n1508, n6147;

    // Neighbour's left layer is rebuilt locally; synthesis shares it.
    assign l1372 = abc[0] & abc[1];
    assign l1508 = abc[0] & abc[1] & ~abc[2];
    assign l6147 = ~abc[0] & ~abc[1] & ~abc[2];
    assign n1372 = abc_nb[0] & abc_nb[1];
    assign n1508 = abc_nb[0] & abc_nb[1] & ~abc_nb[2];
    assign n6147 = ~abc_nb[0] & ~abc_nb[1] & ~abc_nb[2];

    assign o[0] = ~(l1372 & n6147);
    assign o[1] = l1508 ^ n1508;
    assign o[2] = ~(l6147 | n1372);
endmodule

module pattern_merge_pipe #(
    parameter int               CH    = 4,
    parameter int               DEPTH = 2,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter int               CNT_W = 16
) (
    input logic            blif_clk_net,
    input logic            blif_reset_net,
    pattern_merge_if.slave bus
);
    localparam int W = 3 * CH;

    logic                      en;
    logic                      hs;
    logic [CH-1:0][2:0]        abc;
    logic [W-1:0]              f_out;
    logic [DEPTH-1:0]          vld_pipe;
    logic [DEPTH-1:0][W-1:0]   dat_pipe;
    logic [SIG_W-1:0]          sig_q;
    logic [SIG_W-1:0]          fold;
    logic [CNT_W-1:0]          cnt_q;

    assign abc = bus.in_p;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        pattern_merge_lane u_lane (
            .abc    (abc[i]),
            .abc_nb (abc[(i + 1) % CH]),
            .o      (f_out[3*i +: 3])
        );
    end

    // Whole pipe advances together; only an empty output slot absorbs bubbles.
    assign en          = bus.out_rdy | ~vld_pipe[DEPTH-1];
    assign bus.in_rdy  = en;
    assign bus.out_vld = vld_pipe[DEPTH-1];
    assign bus.out_p   = dat_pipe[DEPTH-1];
    assign hs          = vld_pipe[DEPTH-1] & bus.out_rdy;

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else if (en) begin
            vld_pipe[0] <= bus.in_vld;
            dat_pipe[0] <= f_out;
            for (int s = 1; s < DEPTH; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    // Output word XOR-folded into SIG_W slices (plain zero-extend when it fits).
    always_comb begin
        fold = '0;
        for (int b = 0; b < W; b++) begin
            fold[b % SIG_W] = fold[b % SIG_W] ^ dat_pipe[DEPTH-1][b];
        end
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net || bus.sig_clr) begin
            sig_q <= '0;
            cnt_q <= '0;
        end else if (hs) begin
            sig_q <= {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.sig     = sig_q;
    assign bus.out_cnt = cnt_q;
endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Directed bench for pattern_merge_pipe: latency, backpressure, MISR,
// sig_clr priority, mid-flight reset and counter wrap on a CNT_W=4 copy.
module tb_pattern_merge_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pattern_merge_if #(.CH(4), .SIG_W(16), .CNT_W(16)) bus ();
  pattern_merge_if #(.CH(4), .SIG_W(16), .CNT_W(4))  b4 ();

  pattern_merge_pipe #(.CH(4), .DEPTH(2), .SIG_W(16), .POLY(16'h1021), .CNT_W(16)) u_dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (bus)
  );

  pattern_merge_pipe #(.CH(4), .DEPTH(2), .SIG_W(16), .POLY(16'h1021), .CNT_W(4)) u_dut4 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (b4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference gate equations, channel by channel.
  function automatic logic [11:0] f_model(input logic [11:0] p);
    logic [11:0] r;
    logic a, b, c, aj, bj, cj;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a  = p[3*i];           b  = p[3*i+1];           c  = p[3*i+2];
      aj = p[3*((i+1)%4)];   bj = p[3*((i+1)%4)+1];   cj = p[3*((i+1)%4)+2];
      r[3*i]   = !(a && b && !aj && !bj && !cj);
      r[3*i+1] = (a && b && !c) != (aj && bj && !cj);
      r[3*i+2] = !((!a && !b && !c) || (aj && bj));
    end
    return r;
  endfunction

  // Called at a negedge with out_rdy=1; one word through, ends after its handshake.
  task automatic send_one(input logic [11:0] p, input logic [11:0] exp);
    bus.in_vld = 1'b1;
    bus.in_p   = p;
    @(negedge clk);
    bus.in_vld = 1'b0;
    #1;
    chk("lat_early_vld", 32'(bus.out_vld), 32'(0));
    @(negedge clk);
    #1;
    chk("lat_out_vld", 32'(bus.out_vld), 32'(1));
    chk("lat_out_p", 32'(bus.out_p), 32'(exp));
    @(negedge clk);
    #1;
    chk("post_hs_vld", 32'(bus.out_vld), 32'(0));
  endtask

  logic [11:0] words [10] = '{12'h000, 12'h003, 12'hFFF, 12'h123, 12'h456,
                              12'h789, 12'hABC, 12'hDEF, 12'h5A5, 12'h0F0};

  initial begin
    int sent, rcv, n, s4;
    bus.in_vld = 1'b0; bus.in_p = '0; bus.out_rdy = 1'b1; bus.sig_clr = 1'b0;
    b4.in_vld  = 1'b0; b4.in_p  = '0; b4.out_rdy  = 1'b1; b4.sig_clr  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_vld", 32'(bus.out_vld), 32'(0));
    chk("rst_out_p",   32'(bus.out_p),   32'(0));
    chk("rst_sig",     32'(bus.sig),     32'(0));
    chk("rst_cnt",     32'(bus.out_cnt), 32'(0));
    chk("rst_in_rdy",  32'(bus.in_rdy),  32'(1));
    @(negedge clk);
    rst = 1'b0;

    // First two words: hand-computed patterns and signatures
    send_one(12'h000, 12'h249);
    chk("w1_sig", 32'(bus.sig),     32'h0249);
    chk("w1_cnt", 32'(bus.out_cnt), 32'(1));
    send_one(12'h003, 12'h64E);
    chk("w2_sig", 32'(bus.sig),     32'h02DC);
    chk("w2_cnt", 32'(bus.out_cnt), 32'(2));

    // Clear with no handshake pending
    bus.sig_clr = 1'b1;
    @(negedge clk);
    bus.sig_clr = 1'b0;
    #1;
    chk("clr_sig", 32'(bus.sig),     32'(0));
    chk("clr_cnt", 32'(bus.out_cnt), 32'(0));

    // Stream of 10 with out_rdy low in cycles 3..5
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
      bus.in_vld  = (sent < 10);
      bus.in_p    = words[(sent < 10) ? sent : 0];
      bus.out_rdy = !(cyc >= 3 && cyc <= 5);
      #1;
      chk("s_in_rdy", 32'(bus.in_rdy), 32'((cyc >= 3 && cyc <= 5) ? 0 : 1));
      if (bus.out_vld) chk("s_out_p", 32'(bus.out_p), 32'(f_model(words[rcv])));
      if (bus.in_vld && bus.in_rdy) sent++;
      if (bus.out_vld && bus.out_rdy) rcv++;
      @(negedge clk);
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    #1;
    chk("s_sent",    32'(sent),          32'(10));
    chk("s_rcv",     32'(rcv),           32'(10));
    chk("s_cnt",     32'(bus.out_cnt),   32'(10));
    chk("s_drained", 32'(bus.out_vld),   32'(0));

    // sig_clr coincident with a handshake wins
    @(negedge clk);
    bus.in_vld = 1'b1; bus.in_p = 12'h000;
    @(negedge clk);
    bus.in_vld = 1'b0;
    @(negedge clk);
    #1;
    chk("c_vld", 32'(bus.out_vld), 32'(1));
    bus.sig_clr = 1'b1;
    @(negedge clk);
    bus.sig_clr = 1'b0;
    #1;
    chk("c_sig", 32'(bus.sig),     32'(0));
    chk("c_cnt", 32'(bus.out_cnt), 32'(0));
    send_one(12'h000, 12'h249);
    chk("c2_sig", 32'(bus.sig),     32'h0249);
    chk("c2_cnt", 32'(bus.out_cnt), 32'(1));

    // Reset with DEPTH words in flight
    bus.in_vld = 1'b1; bus.in_p = 12'h003;
    @(negedge clk);
    @(negedge clk);
    bus.in_vld = 1'b0;
    #1;
    chk("r_pre_vld", 32'(bus.out_vld), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("r_out_vld", 32'(bus.out_vld), 32'(0));
    chk("r_sig",     32'(bus.sig),     32'(0));
    chk("r_cnt",     32'(bus.out_cnt), 32'(0));
    chk("r_in_rdy",  32'(bus.in_rdy),  32'(1));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("r_no_stale", 32'(bus.out_vld), 32'(0));
    end
    chk("r_cnt_after", 32'(bus.out_cnt), 32'(0));

    // CNT_W=4 copy: 17 handshakes wrap the counter to 1
    @(negedge clk);
    n = 0; s4 = 0;
    for (int cyc = 0; cyc < 60 && n < 17; cyc++) begin
      b4.in_vld = (s4 < 17);
      #1;
      chk("w_cnt", 32'(b4.out_cnt), 32'(n % 16));
      if (b4.in_vld && b4.in_rdy) s4++;
      if (b4.out_vld && b4.out_rdy) n++;
      @(negedge clk);
    end
    b4.in_vld = 1'b0;
    #1;
    chk("w_hs",    32'(n),           32'(17));
    chk("w_final", 32'(b4.out_cnt), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
